sa_out_drain: RTL and testbench

//  Read-side companion of the output-stationary 2D systolic array (sa_2D).
//  - On START, snapshots the flattened MAC result bus Y into a shadow register.
//  - Streams the snapshot out one PE row per beat on a valid/ready interface.
//  - The array is free to clear and start its next tile while the drain empties.

---
 rtl/sa_out_drain.sv | 150 +++++++++++++++
 tb/tb_sa_out_drain.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_out_drain.sv
// Drain stage for the output-stationary systolic array: snapshots the result bus and
// streams it out one PE row per beat. Optional OUT_LAST sideband under SA_DRAIN_LAST_EN.
module sa_out_drain #(
  parameter int HPE   = 8,
  parameter int VPE   = 8,
  parameter int WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [2*WIDTH*HPE*VPE-1:0]    i_y,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [2*WIDTH*HPE-1:0]        o_out_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_ovf
`ifdef SA_DRAIN_LAST_EN
  ,output logic                         o_out_last
`endif
);

  localparam int P    = 2 * WIDTH;
  localparam int ROWW = P * HPE;
  localparam int YW   = ROWW * VPE;
  localparam int RW   = (VPE > 1) ? $clog2(VPE) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(VPE - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t          r_state, w_state;
  logic [RW-1:0]   r_row, w_row;
  logic [YW-1:0]   r_shadow, w_shadow;
  logic            r_valid, w_valid;
  logic [ROWW-1:0] r_data, w_data;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_ovf, w_ovf;
  logic            w_xfer;
  logic            w_final;
`ifdef SA_DRAIN_LAST_EN
  logic            r_last, w_last;
`endif

  // Row 0 sits in the MSBs of the flattened bus, so row i starts at (VPE-1-i) rows up.
  function automatic logic [ROWW-1:0] selectRow(input logic [YW-1:0] src,
                                                input logic [RW-1:0] row);
    logic [ROWW-1:0] res;
    res = '0;
    for (int i = 0; i < VPE; i++) begin
      if (row == RW'(i)) res = src[(VPE-1-i)*ROWW +: ROWW];
    end
    return res;
  endfunction

  assign w_xfer  = r_valid & i_out_ready;
  assign w_final = w_xfer & (r_row == LAST_ROW);

  always_comb begin
    w_state  = r_state;
    w_row    = r_row;
    w_shadow = r_shadow;
    w_valid  = r_valid;
    w_data   = r_data;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_ovf    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state  = S_STREAM;
          w_shadow = i_y;
          w_row    = '0;
          w_valid  = 1'b1;
          w_busy   = 1'b1;
          w_data   = selectRow(i_y, '0);
        end
      end
      S_STREAM: begin
        if (w_final) begin
          w_done = 1'b1;
          // A START landing on the final transfer chains straight into the next tile.
          if (i_start) begin
            w_shadow = i_y;
            w_row    = '0;
            w_data   = selectRow(i_y, '0);
          end else begin
            w_state = S_IDLE;
            w_row   = '0;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_data  = '0;
          end
        end else begin
          if (w_xfer) begin
            w_row  = r_row + 1'b1;
            w_data = selectRow(r_shadow, w_row);
          end
          if (i_start) w_ovf = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

`ifdef SA_DRAIN_LAST_EN
  assign w_last = w_valid & (w_row == LAST_ROW);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_shadow <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SA_DRAIN_LAST_EN
      r_last   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_row    <= w_row;
      r_shadow <= w_shadow;
      r_valid  <= w_valid;
      r_data   <= w_data;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_ovf    <= w_ovf;
`ifdef SA_DRAIN_LAST_EN
      r_last   <= w_last;
`endif
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;
`ifdef SA_DRAIN_LAST_EN
  assign o_out_last  = r_last;
`endif

endmodule

// File: tb/tb_sa_out_drain.sv
// Self-checking bench for sa_out_drain: directed scenarios plus random traffic against
// a queue-based reference model. 2x2 array by default, 4x4 with SA_DRAIN_LAST_EN.
module tb_sa_out_drain;

`ifdef SA_DRAIN_LAST_EN
  localparam int HPE = 4;
  localparam int VPE = 4;
  localparam int FLG = 5;
`else
  localparam int HPE = 2;
  localparam int VPE = 2;
  localparam int FLG = 4;
`endif
  localparam int WIDTH = 8;
  localparam int P     = 2 * WIDTH;
  localparam int N     = HPE * VPE;
  localparam int ROWW  = P * HPE;
  localparam int YW    = ROWW * VPE;
  localparam int VW    = ROWW + FLG;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [YW-1:0]   yIn;
  logic            outValid;
  logic            outReady;
  logic [ROWW-1:0] outData;
  logic            busy;
  logic            done;
  logic            ovf;
`ifdef SA_DRAIN_LAST_EN
  logic            outLast;
`endif

  int checks = 0;
  int errors = 0;

  logic [ROWW-1:0] q[$];
  logic            mDone;
  logic            mOvf;

  sa_out_drain #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_y         (yIn),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_busy      (busy),
    .o_done      (done),
    .o_ovf       (ovf)
`ifdef SA_DRAIN_LAST_EN
    ,.o_out_last (outLast)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference row: concatenate words k=r*HPE+c, word 0 of the row landing in the MSBs.
  function automatic logic [ROWW-1:0] rowOf(input logic [YW-1:0] y, input int r);
    logic [ROWW-1:0] row;
    row = '0;
    for (int c = 0; c < HPE; c++) begin
      int k;
      k = r * HPE + c;
      row[(HPE-c)*P-1 -: P] = y[(N-k)*P-1 -: P];
    end
    return row;
  endfunction

  function automatic logic [VW-1:0] expVec();
    logic            v;
    logic [ROWW-1:0] d;
    v = (q.size() > 0);
    d = v ? q[0] : '0;
`ifdef SA_DRAIN_LAST_EN
    return {v, v, mDone, mOvf, (q.size() == 1), d};
`else
    return {v, v, mDone, mOvf, d};
`endif
  endfunction

  function automatic logic [VW-1:0] obsVec();
    logic [ROWW-1:0] d;
    d = outValid ? outData : '0;
`ifdef SA_DRAIN_LAST_EN
    return {outValid, busy, done, ovf, outLast, d};
`else
    return {outValid, busy, done, ovf, d};
`endif
  endfunction

  function automatic logic [YW-1:0] randomY();
    logic [YW-1:0] y;
    for (int i = 0; i < YW / 32; i++) y[i*32 +: 32] = $urandom();
    return y;
  endfunction

  function automatic void modelReset();
    q.delete();
    mDone = 1'b0;
    mOvf  = 1'b0;
  endfunction

  // Applies one cycle of inputs and advances the model by the same clock edge.
  task automatic applyStimulus(input logic s, input logic rdy, input logic [YW-1:0] y);
    logic wasBusy, xfer, fin;
    start    = s;
    outReady = rdy;
    yIn      = y;
    @(posedge clk);
    wasBusy = (q.size() > 0);
    xfer    = wasBusy && rdy;
    fin     = xfer && (q.size() == 1);
    if (xfer) void'(q.pop_front());
    mDone = fin;
    if (s) begin
      if (!wasBusy || fin) begin
        for (int r = 0; r < VPE; r++) q.push_back(rowOf(y, r));
      end else begin
        mOvf = 1'b1;
      end
    end
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    modelReset();
    #2;
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_async got %h expected %h", obsVec(), expVec());
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, randomY());
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_idle step %0d got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 1'b1, YW'(64'h0001_0002_0003_0004));
    for (int i = 0; i < VPE + 2; i++) begin
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL basic step %0d got %h expected %h", i, obsVec(), expVec());
      end
      applyStimulus(1'b0, 1'b1, '0);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 1'b0, YW'(64'h0001_0002_0003_0004));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL backpressure_hold %0d got %h expected %h", i, obsVec(), expVec());
      end
    end
    for (int i = 0; i < VPE + 1; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL backpressure_drain %0d got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_overrun();
    applyStimulus(1'b1, 1'b1, YW'(64'h0001_0002_0003_0004));
    applyStimulus(1'b1, 1'b1, '1);
    for (int i = 0; i < VPE + 3; i++) begin
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL overrun step %0d got %h expected %h", i, obsVec(), expVec());
      end
      applyStimulus(1'b0, 1'b1, '1);
    end
  endtask

  task automatic test_back_to_back();
    int doneCount;
    doneCount = 0;
    applyStimulus(1'b1, 1'b1, YW'(64'h0001_0002_0003_0004));
    for (int i = 0; i < VPE - 1; i++) applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, YW'(64'hA0A0_B1B1_C2C2_D3D3));
    for (int i = 0; i < VPE + 2; i++) begin
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d got %h expected %h", i, obsVec(), expVec());
      end
      if (done) doneCount++;
      applyStimulus(1'b0, 1'b1, '0);
    end
    checks++;
    if (doneCount !== 2) begin
      errors++;
      $display("[TB] FAIL back_to_back_done_count got %0d expected 2", doneCount);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 1'b1, YW'(64'h0001_0002_0003_0004));
    applyStimulus(1'b1, 1'b0, '0);
    #3 rst_n = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL async_reset got %h expected %h", obsVec(), expVec());
    end
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, YW'(64'hA0A0_B1B1_C2C2_D3D3));
    for (int i = 0; i < VPE + 2; i++) begin
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL async_restart step %0d got %h expected %h", i, obsVec(), expVec());
      end
      applyStimulus(1'b0, 1'b1, '0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), randomY());
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random step %0d got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  initial begin
    start    = 1'b0;
    outReady = 1'b0;
    yIn      = '0;
    modelReset();
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
